// File: rtl/fsgn_rs_pkg.sv
// Shared types for the FP sign-manipulation reservation station.
//   cdb_t        : {valid, tag, data} payload used by the FPR CDB and register reads
//   fsgn_op_t    : sign-manipulation opcode
//   fsgn_entry_t : one reservation-station entry
//   tag_match    : true when a CDB broadcast carries the given producer tag
package fsgn_rs_pkg;

  localparam int unsigned ROB_WIDTH  = 6;
  localparam int unsigned DATA_WIDTH = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

  typedef enum logic [2:0] {
    OP_FMOV    = 3'b000,
    OP_FNEG    = 3'b001,
    OP_FABS    = 3'b010,
    OP_FNABS   = 3'b011,
    OP_FSGNJ   = 3'b100,
    OP_FSGNJN  = 3'b101,
    OP_FSGNJX  = 3'b110,
    OP_ILLEGAL = 3'b111
  } fsgn_op_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    fsgn_op_t             op;
    cdb_t [1:0]           opd;
  } fsgn_entry_t;

  function automatic logic tag_match(input cdb_t bus, input logic [ROB_WIDTH-1:0] t);
    return bus.valid && (bus.tag == t);
  endfunction

endpackage

// File: rtl/fsgn_unit.sv
// Combinational sign-manipulation datapath; one instance per dispatch candidate.
//   op       : operation
//   a        : operand 0 (magnitude bits always pass through)
//   b_sign   : sign bit of operand 1 (only sign-injection ops use it)
//   result_c : computed value
module fsgn_unit
  import fsgn_rs_pkg::*;
(
  input  fsgn_op_t    op,
  input  logic [31:0] a,
  input  logic        b_sign,
  output logic [31:0] result_c
);

  logic sign_c;

  always_comb begin
    sign_c = a[31];
    case (op)
      OP_FMOV:   sign_c = a[31];
      OP_FNEG:   sign_c = ~a[31];
      OP_FABS:   sign_c = 1'b0;
      OP_FNABS:  sign_c = 1'b1;
      OP_FSGNJ:  sign_c = b_sign;
      OP_FSGNJN: sign_c = ~b_sign;
      OP_FSGNJX: sign_c = a[31] ^ b_sign;
      default:   sign_c = a[31];
    endcase
  end

  assign result_c = {sign_c, a[30:0]};

endmodule

// File: rtl/fsgn_rs.sv
// Reservation station + execute stage for FP sign-manipulation ops.
// Entries are kept compacted toward index 0 (oldest); the incoming issue is an
// extra, lowest-priority dispatch candidate (bypass).
//   clk, reset    : clock, synchronous active-high reset
//   flush         : discards all entries, blocks dispatch and allocation
//   issue_*       : allocation request / handshake
//   opd_read      : register-file read result per operand
//   cdb           : FPR CDB broadcast snooped for pending operands
//   cdb_req_valid : a dispatchable candidate exists (combinational)
//   cdb_req_ready : CDB grant
//   tag           : ROB tag of the selected candidate (combinational)
//   result        : registered result, meaningful the cycle after a grant
//   occupancy     : number of valid stored entries
module fsgn_rs
  import fsgn_rs_pkg::*;
#(
  parameter int unsigned N_ENTRY = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  logic [2:0]                       issue_op,
  input  logic [ROB_WIDTH-1:0]             issue_tag,
  input  cdb_t [1:0]                       opd_read,
  input  cdb_t                             cdb,
  output logic                             cdb_req_valid,
  input  logic                             cdb_req_ready,
  output logic [ROB_WIDTH-1:0]             tag,
  output logic [31:0]                      result,
  output logic [$clog2(N_ENTRY+1)-1:0]     occupancy
);

  localparam int unsigned IDX_W = $clog2(N_ENTRY + 1);

  fsgn_entry_t       e_q   [N_ENTRY];
  fsgn_entry_t       nxt   [N_ENTRY];
  fsgn_entry_t       upd   [N_ENTRY+1];   // index N_ENTRY is the incoming issue
  logic [31:0]       res_c [N_ENTRY+1];
  logic [N_ENTRY:0]  rdy_c;
  fsgn_entry_t       inc_c;
  logic [IDX_W-1:0]  sel_c;
  logic              any_c;
  logic              dispatch_c;
  logic              bypass_disp_c;
  logic              stored_disp_c;
  logic              accept_c;
  logic [31:0]       sel_res_c;
  logic [IDX_W-1:0]  occ_c;

  // Incoming entry as seen from the register read; one-operand ops never wait on operand 1.
  always_comb begin
    inc_c       = '0;
    inc_c.valid = issue_valid;
    inc_c.tag   = issue_tag;
    inc_c.op    = fsgn_op_t'(issue_op);
    inc_c.opd   = opd_read;
    if (!issue_op[2]) begin
      inc_c.opd[1].valid = 1'b1;
    end
  end

  // Per-candidate CDB capture, readiness and result computation.
  for (genvar i = 0; i <= N_ENTRY; i++) begin : g_cand
    fsgn_entry_t src;
    fsgn_entry_t u;

    if (i == N_ENTRY) begin : g_inc
      assign src = inc_c;
    end else begin : g_st
      assign src = e_q[i];
    end

    // A valid read wins over a simultaneous CDB match because capture only fills pending operands.
    always_comb begin
      u = src;
      for (int j = 0; j < 2; j++) begin
        if (!src.opd[j].valid && tag_match(cdb, src.opd[j].tag)) begin
          u.opd[j].valid = 1'b1;
          u.opd[j].data  = cdb.data;
        end
      end
    end

    assign upd[i]   = u;
    assign rdy_c[i] = u.valid && u.opd[0].valid && u.opd[1].valid;

    fsgn_unit u_unit (
      .op       (u.op),
      .a        (u.opd[0].data),
      .b_sign   (u.opd[1].data[31]),
      .result_c (res_c[i])
    );
  end

  // Oldest ready candidate wins; descending scan lets the lowest index overwrite.
  always_comb begin
    sel_c = IDX_W'(N_ENTRY);
    any_c = 1'b0;
    for (int i = N_ENTRY; i >= 0; i--) begin
      if (rdy_c[i]) begin
        sel_c = IDX_W'(i);
        any_c = 1'b1;
      end
    end
  end

  assign cdb_req_valid = any_c && !flush;
  assign dispatch_c    = cdb_req_valid && cdb_req_ready;
  assign bypass_disp_c = dispatch_c && (sel_c == IDX_W'(N_ENTRY));
  assign stored_disp_c = dispatch_c && (sel_c != IDX_W'(N_ENTRY));
  assign tag           = upd[sel_c].tag;
  assign sel_res_c     = any_c ? res_c[sel_c] : 32'h0;
  assign issue_ready   = !flush && (dispatch_c || !e_q[N_ENTRY-1].valid);
  assign accept_c      = issue_valid && issue_ready;

  // Close the gap left by a stored dispatch, then append a non-bypassed issue.
  always_comb begin
    logic placed;
    placed = 1'b0;
    for (int i = 0; i < N_ENTRY; i++) begin
      nxt[i] = upd[i];
    end
    if (stored_disp_c) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        if (IDX_W'(i) >= sel_c) begin
          if (i < N_ENTRY - 1) begin
            nxt[i] = upd[i+1];
          end else begin
            nxt[i] = '0;
          end
        end
      end
    end
    if (accept_c && !bypass_disp_c) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        if (!placed && !nxt[i].valid) begin
          nxt[i] = upd[N_ENTRY];
          placed = 1'b1;
        end
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        e_q[i] <= '0;
      end
    end else begin
      e_q <= nxt;
    end
  end

  // Result register tracks the selected candidate every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= 32'h0;
    end else begin
      result <= sel_res_c;
    end
  end

  // Occupancy counts stored valid bits.
  always_comb begin
    occ_c = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      occ_c = occ_c + IDX_W'(e_q[i].valid);
    end
  end

  assign occupancy = occ_c;

endmodule

// File: tb/tb_fsgn_rs.sv
module tb_fsgn_rs;
  import fsgn_rs_pkg::*;

  localparam int unsigned N = 4;

  logic                 clk;
  logic                 reset;
  logic                 flush;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [2:0]           issue_op;
  logic [ROB_WIDTH-1:0] issue_tag;
  cdb_t [1:0]           opd_read;
  cdb_t                 cdb;
  logic                 cdb_req_valid;
  logic                 cdb_req_ready;
  logic [ROB_WIDTH-1:0] tag;
  logic [31:0]          result;
  logic [2:0]           occupancy;

  fsgn_rs #(.N_ENTRY(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_tag     (issue_tag),
    .opd_read      (opd_read),
    .cdb           (cdb),
    .cdb_req_valid (cdb_req_valid),
    .cdb_req_ready (cdb_req_ready),
    .tag           (tag),
    .result        (result),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: age-ordered queue of waiting instructions.
  typedef struct {
    logic [5:0]  tag;
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    bit          a_ok;
    bit          b_ok;
    logic [5:0]  at;
    logic [5:0]  bt;
  } m_ent_t;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] res;
    bit          dc;
  } disp_t;

  typedef struct {
    bit         irdy;
    bit         rv;
    logic [5:0] tag;
    int         occ;
  } stat_t;

  m_ent_t mq[$];
  disp_t  dq[$];
  stat_t  sq[$];

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
    logic s;
    case (op)
      0: s = a[31];
      1: s = ~a[31];
      2: s = 1'b0;
      3: s = 1'b1;
      4: s = b[31];
      5: s = ~b[31];
      6: s = a[31] ^ b[31];
      default: s = 1'b0;
    endcase
    return {s, a[30:0]};
  endfunction

  function automatic cdb_t mk(input bit v, input logic [5:0] t, input logic [31:0] d);
    cdb_t r;
    r.valid = v;
    r.tag   = t;
    r.data  = d;
    return r;
  endfunction

  // Evaluate one cycle of the reference model on the currently driven inputs.
  task automatic model_step();
    m_ent_t inc;
    int     sel;
    bit     found, rv, disp, irdy;
    stat_t  s;
    disp_t  d;
    if (reset) begin
      mq.delete();
      return;
    end
    s.occ = mq.size();
    foreach (mq[i]) begin
      if (!mq[i].a_ok && cdb.valid && cdb.tag == mq[i].at) begin
        mq[i].a = cdb.data; mq[i].a_ok = 1;
      end
      if (!mq[i].b_ok && cdb.valid && cdb.tag == mq[i].bt) begin
        mq[i].b = cdb.data; mq[i].b_ok = 1;
      end
    end
    inc.tag = issue_tag;
    inc.op  = int'(issue_op);
    inc.at  = opd_read[0].tag;
    inc.bt  = opd_read[1].tag;
    inc.a   = 32'h0;
    inc.b   = 32'h0;
    inc.a_ok = 0;
    inc.b_ok = 0;
    if (opd_read[0].valid) begin inc.a = opd_read[0].data; inc.a_ok = 1; end
    else if (cdb.valid && cdb.tag == opd_read[0].tag) begin inc.a = cdb.data; inc.a_ok = 1; end
    if (inc.op < 4) inc.b_ok = 1;
    else if (opd_read[1].valid) begin inc.b = opd_read[1].data; inc.b_ok = 1; end
    else if (cdb.valid && cdb.tag == opd_read[1].tag) begin inc.b = cdb.data; inc.b_ok = 1; end

    found = 0;
    sel   = -1;
    foreach (mq[i]) begin
      if (!found && mq[i].a_ok && mq[i].b_ok) begin found = 1; sel = i; end
    end
    if (!found && issue_valid && inc.a_ok && inc.b_ok) found = 1;

    rv   = found && !flush;
    disp = rv && cdb_req_ready;
    irdy = !flush && (disp || mq.size() < N);
    s.irdy = irdy;
    s.rv   = rv;
    s.tag  = (sel >= 0) ? mq[sel].tag : inc.tag;
    sq.push_back(s);

    if (disp) begin
      if (sel >= 0) begin
        d.tag = mq[sel].tag; d.res = ref_res(mq[sel].op, mq[sel].a, mq[sel].b); d.dc = (mq[sel].op == 7);
      end else begin
        d.tag = inc.tag; d.res = ref_res(inc.op, inc.a, inc.b); d.dc = (inc.op == 7);
      end
      dq.push_back(d);
    end

    if (flush) mq.delete();
    else begin
      if (disp && sel >= 0) mq.delete(sel);
      if (issue_valid && irdy && !(disp && sel < 0)) mq.push_back(inc);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0;
    issue_op    = 3'd0;
    issue_tag   = 6'd0;
    flush       = 0;
    cdb         = '0;
    opd_read    = '0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] t, input cdb_t r0, input cdb_t r1);
    issue_valid = 1;
    issue_op    = op;
    issue_tag   = t;
    opd_read[0] = r0;
    opd_read[1] = r1;
  endtask

  // Monitor: compares DUT outputs against model expectations at the falling edge.
  initial begin
    bit          res_pend;
    logic [31:0] res_exp;
    bit          res_dc;
    stat_t       s;
    disp_t       d;
    res_pend = 0;
    res_exp  = 32'h0;
    res_dc   = 0;
    forever begin
      @(negedge clk);
      if (res_pend) begin
        res_pend = 0;
        if (!res_dc) chk("result", result, res_exp);
      end
      if (!reset && sq.size() > 0) begin
        s = sq.pop_front();
        chk("issue_ready", 32'(issue_ready), 32'(s.irdy));
        chk("cdb_req_valid", 32'(cdb_req_valid), 32'(s.rv));
        chk("occupancy", 32'(occupancy), 32'(s.occ));
        if (s.rv) chk("tag", 32'(tag), 32'(s.tag));
      end
      if (!reset && cdb_req_valid && cdb_req_ready) begin
        chk("dispatch_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) begin
          d = dq.pop_front();
          chk("dispatch_tag", 32'(tag), 32'(d.tag));
          res_pend = 1;
          res_exp  = d.res;
          res_dc   = d.dc;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [5:0] tag_ctr;
    n_pass  = 0;
    n_total = 0;
    tag_ctr = 6'd0;
    reset = 1;
    cdb_req_ready = 0;
    idle();
    cyc();
    cyc();

    // Reset state.
    reset = 0;
    #1;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_cdb_req_valid", 32'(cdb_req_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_result", result, 32'h0);

    // fneg bypass.
    cdb_req_ready = 1;
    issue(3'd1, 6'd1, mk(1, 6'd0, 32'h3F800000), mk(0, 6'd0, 32'h0));
    #1;
    chk("byp_valid", 32'(cdb_req_valid), 32'd1);
    chk("byp_tag", 32'(tag), 32'd1);
    cyc();
    idle();
    #1;
    chk("byp_result", result, 32'hBF800000);
    chk("byp_occ", 32'(occupancy), 32'd0);

    // fsgnj waits for operand 1 from the CDB.
    issue(3'd4, 6'd2, mk(1, 6'd0, 32'h40000000), mk(0, 6'd5, 32'h0));
    cyc();
    idle();
    cyc();
    cdb = mk(1, 6'd5, 32'h80000001);
    #1;
    chk("sgnj_valid", 32'(cdb_req_valid), 32'd1);
    chk("sgnj_tag", 32'(tag), 32'd2);
    cyc();
    idle();
    #1;
    chk("sgnj_result", result, 32'hC0000000);

    // Fill with pending entries, wake entry 2 then entry 0.
    cdb_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      issue(3'd0, 6'(10 + i), mk(0, 6'(i + 1), 32'h0), mk(0, 6'd0, 32'h0));
      cyc();
    end
    issue(3'd0, 6'd50, mk(1, 6'd0, 32'h1), mk(0, 6'd0, 32'h0));
    #1;
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_issue_ready", 32'(issue_ready), 32'd0);
    cyc();
    idle();
    cdb = mk(1, 6'd3, 32'hAAAA0003);
    cyc();
    cdb = mk(1, 6'd1, 32'h55550001);
    cyc();
    idle();
    cdb_req_ready = 1;
    #1;
    chk("order_first_tag", 32'(tag), 32'd10);
    cyc();
    cyc();
    cdb = mk(1, 6'd2, 32'h00000002);
    cyc();
    cdb = mk(1, 6'd4, 32'h80000004);
    cyc();
    idle();
    cyc();

    // Full + dispatch of entry 1 + issue in the same cycle.
    cdb_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      issue(3'd0, 6'(30 + i), mk(0, 6'(20 + i), 32'h0), mk(0, 6'd0, 32'h0));
      cyc();
    end
    idle();
    cdb = mk(1, 6'd21, 32'h12345678);
    cyc();
    cdb_req_ready = 1;
    issue(3'd0, 6'd34, mk(0, 6'd24, 32'h0), mk(0, 6'd0, 32'h0));
    #1;
    chk("fdi_tag", 32'(tag), 32'd31);
    chk("fdi_issue_ready", 32'(issue_ready), 32'd1);
    cyc();
    idle();
    cdb_req_ready = 0;
    #1;
    chk("fdi_occ", 32'(occupancy), 32'd4);
    cdb = mk(1, 6'd24, 32'hC0000024); cyc();
    cdb = mk(1, 6'd23, 32'h00000023); cyc();
    cdb = mk(1, 6'd22, 32'h80000022); cyc();
    cdb = mk(1, 6'd20, 32'h00000020); cyc();
    idle();
    cdb_req_ready = 1;
    for (int i = 0; i < 5; i++) cyc();

    // Flush with three entries, two ready.
    cdb_req_ready = 0;
    issue(3'd0, 6'd40, mk(1, 6'd0, 32'h11111111), mk(0, 6'd0, 32'h0)); cyc();
    issue(3'd0, 6'd41, mk(0, 6'd6, 32'h0), mk(0, 6'd0, 32'h0));        cyc();
    issue(3'd0, 6'd42, mk(1, 6'd0, 32'h22222222), mk(0, 6'd0, 32'h0)); cyc();
    issue(3'd0, 6'd43, mk(1, 6'd0, 32'h33333333), mk(0, 6'd0, 32'h0));
    flush = 1;
    cdb_req_ready = 1;
    #1;
    chk("flush_req_valid", 32'(cdb_req_valid), 32'd0);
    chk("flush_issue_ready", 32'(issue_ready), 32'd0);
    cyc();
    idle();
    #1;
    chk("flush_occ", 32'(occupancy), 32'd0);
    issue(3'd2, 6'd44, mk(1, 6'd0, 32'hC0490FDB), mk(0, 6'd0, 32'h0));
    cyc();
    idle();
    #1;
    chk("post_flush_result", result, 32'h40490FDB);

    // Reset mid-stream with issue_valid held.
    cdb_req_ready = 0;
    issue(3'd0, 6'd45, mk(1, 6'd0, 32'h45), mk(0, 6'd0, 32'h0)); cyc();
    issue(3'd0, 6'd46, mk(1, 6'd0, 32'h46), mk(0, 6'd0, 32'h0)); cyc();
    reset = 1;
    issue(3'd0, 6'd47, mk(1, 6'd0, 32'h47), mk(0, 6'd0, 32'h0));
    cyc();
    cyc();
    reset = 0;
    idle();
    #1;
    chk("mid_rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("mid_rst_req_valid", 32'(cdb_req_valid), 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      issue_valid   = 1'($urandom_range(0, 1));
      issue_op      = 3'($urandom_range(0, 7));
      issue_tag     = tag_ctr;
      tag_ctr       = tag_ctr + 6'd1;
      opd_read[0]   = mk($urandom_range(0, 9) < 6, 6'($urandom_range(0, 7)), $urandom());
      opd_read[1]   = mk($urandom_range(0, 9) < 6, 6'($urandom_range(0, 7)), $urandom());
      cdb           = mk($urandom_range(0, 9) < 4, 6'($urandom_range(0, 7)), $urandom());
      cdb_req_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 99) < 3);
      cyc();
    end

    idle();
    cdb_req_ready = 0;
    cyc();
    cyc();
    cyc();
    chk("dispatch_queue_drained", 32'(dq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fsgn_rs.md
Name: fsgn_rs

Overview:
- Parametrised reservation station plus execute stage for FP sign-manipulation ops: fmov, fneg, fabs, fnabs, fsgnj, fsgnjn, fsgnjx.
- Sits between the FP issue stage and the FPR common data bus (CDB).
- Holds up to N_ENTRY in-order-allocated entries and snoops the CDB for pending operands.
- Dispatches the oldest ready entry and drives its result onto the CDB with a one-cycle registered data path.
- Unlike the previous generation, it handles two-operand sign-injection ops, arbitrary depth, a flush input and an occupancy output.

Parameters:
- N_ENTRY, 4: number of stored entries, must be >= 2.
- ROB_WIDTH, package value: width of ROB tags.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  mispredict flush; discards all entries.
- issue_valid  in  1  issue request.
- issue_ready  out  1  station can accept an entry this cycle.
- issue_op  in  3  000 fmov, 001 fneg, 010 fabs, 011 fnabs, 100 fsgnj, 101 fsgnjn, 110 fsgnjx; 111 is illegal.
- issue_tag  in  ROB_WIDTH  destination ROB tag.
- opd_read[1:0]  in  cdb_t  register-file read result {valid, tag, data}; opd_read[1] is ignored for ops 0xx.
- cdb  in  cdb_t  FPR CDB broadcast, compared via tag_match.
- cdb_req_valid  out  1  a dispatchable entry exists.
- cdb_req_ready  in  1  CDB grant.
- tag  out  ROB_WIDTH  tag of the dispatching entry; same cycle as cdb_req_valid.
- result  out  32  registered result; valid the cycle after grant.
- occupancy  out  $clog2(N_ENTRY+1)  number of valid stored entries.

Behaviour:
- Entry fields: valid, tag, op, opd[1:0] {valid, tag, data}.
- Operand 1 of a one-operand op is marked valid at allocation.
- Operand capture, per operand, on allocation and every cycle while pending: ready if opd_read.valid, or if tag_match(cdb, opd.tag). The CDB data is used when the read is not valid.
- A read that is valid and also matches the CDB is a don't-care case; the implementation must prefer opd_read.
- Compute from the updated operands a = opd[0].data and b = opd[1].data:
  - fmov: a
  - fneg: {~a[31], a[30:0]}
  - fabs: {0, a[30:0]}
  - fnabs: {1, a[30:0]}
  - fsgnj: {b[31], a[30:0]}
  - fsgnjn: {~b[31], a[30:0]}
  - fsgnjx: {a[31]^b[31], a[30:0]}
  - The data bits a[30:0] always pass through untouched.
- Ordering: entries are compacted toward index 0, and index 0 is the oldest.
- A candidate is dispatchable when it is valid and all needed operands are valid after the CDB update.
- Candidates are the stored entries 0..N_ENTRY-1 plus the incoming issue (bypass), which has the lowest priority.
- Dispatch selects the lowest-index dispatchable candidate.
- cdb_req_valid = any candidate dispatchable and not flush.
- tag is driven combinationally from the selected candidate.
- dispatch = cdb_req_valid && cdb_req_ready.
- result is registered on every clock edge from the selected candidate's computed value; it is meaningful only in the cycle after dispatch. Reset value: 0.
- issue_ready = !flush && (dispatch || !e[N_ENTRY-1].valid).
- Accepted issue = issue_valid && issue_ready.
- Next-state update on a dispatch of stored index k:
  - Entries above k shift down by one.
  - An accepted, non-bypassed issue lands in the first free slot after the shift.
- If the bypass itself dispatches, the issue is not stored.
- When full with no dispatch, issue_ready=0 and issue_valid is ignored.
- Every stored entry latches its CDB-updated operands each cycle.
- Reset or flush: all entry valid bits clear at the next edge; occupancy becomes 0 the cycle after.
- During a flush cycle: no dispatch, no allocation, and cdb_req_valid=0.
- Reset values: issue_ready=1 after reset, cdb_req_valid=0, occupancy=0, result=0.
- Boundary cases:
  - Full plus dispatch plus issue in the same cycle: the new entry occupies slot N_ENTRY-1.
  - CDB broadcast of an operand's tag in the cycle an entry allocates: the entry captures it.
  - Both operands arrive in the same cycle from read and CDB: the entry is dispatchable that cycle.
- Illegal op 111 must not corrupt other entries; its result is don't-care.

Decomposition:
- Shared package (common.vh): cdb_t, ROB_WIDTH, tag_match, plus a new fsgn_op_t enum and a fsgn_entry_t struct.
- One sub-module, fsgn_unit: combinational op, a, b -> result; reused per candidate.
- Selection, shift and allocation logic lives in a generate loop inside fsgn_rs.

Test Plan:
- Issue fneg with operand ready, a=0x3F800000, cdb_req_ready=1 -> same cycle cdb_req_valid=1 with tag = issue tag; next cycle result=0xBF800000; occupancy stays 0.
- Issue fsgnj with a ready =0x40000000 and b pending tag 5; a later CDB broadcast of tag 5 with data 0x80000001 -> dispatch in the CDB cycle (bypass from stored entry); result=0xC0000000.
- Fill N_ENTRY entries with pending tags 1..4 and hold cdb_req_ready=0 -> issue_ready=0 and occupancy=4. CDB tags 3 then 1 -> entry 0 dispatches before entry 2 once both are ready; ordering is preserved after the shift.
- Full station with entry 1 ready, cdb_req_ready=1 and issue_valid=1 in the same cycle -> dispatch of entry 1, shift, new entry stored in slot 3, occupancy stays 4.
- flush asserted with 3 entries, two of them ready -> cdb_req_valid=0 and issue_ready=0 that cycle; occupancy=0 next cycle; later issue accepted normally.
- Reset asserted mid-stream with issue_valid held -> no allocation; issue_ready=1, cdb_req_valid=0 and result=0 after reset.
